// File: rtl/tpu_pkg.sv
// Shared TPU definitions: weight word/address types, default weight memory geometry
// and the weight loader state encoding.
package tpu_pkg;

  localparam int unsigned WEIGHT_N      = 2;
  localparam int unsigned WEIGHT_DEPTH  = 32;
  localparam int unsigned WEIGHT_DATA_W = 16;
  localparam int unsigned WEIGHT_ADDR_W = 13;

  typedef logic [WEIGHT_DATA_W-1:0] weight_t;
  typedef logic [WEIGHT_ADDR_W-1:0] waddr_t;

  typedef enum logic {
    WL_IDLE = 1'b0,
    WL_LOAD = 1'b1
  } wl_state_e;

endpackage

// File: rtl/weight_loader_addr_gen.sv
// Row/column beat counters for a row-major N x N stream and the matching
// column-major (transposed) memory address.
module transpose_addr_gen #(
  parameter int unsigned N      = 2,
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  logic [CNT_W-1:0] row;
  logic [CNT_W-1:0] col;
  logic             col_end;
  logic             row_end;

  assign col_end = (col == CNT_W'(N - 1));
  assign row_end = (row == CNT_W'(N - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // The range check at start time guarantees this sum never exceeds ADDR_W bits.
  assign addr = base + (ADDR_W'(col) * ADDR_W'(N)) + ADDR_W'(row);
  assign last = col_end && row_end;

endmodule

// File: rtl/weight_loader.sv
// Streams one row-major N x N weight matrix per start command into the weight
// memory at transposed addresses, so a column is contiguous from the base.
module weight_loader
  import tpu_pkg::*;
#(
  parameter int unsigned N      = WEIGHT_N,
  parameter int unsigned DATA_W = WEIGHT_DATA_W,
  parameter int unsigned ADDR_W = WEIGHT_ADDR_W,
  parameter int unsigned DEPTH  = WEIGHT_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  wl_state_e         state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   end_addr;
  logic              in_range;
  logic              start_ok;
  logic              accept;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_last;

  assign end_addr = {1'b0, base_addr} + (ADDR_W + 1)'(N * N);
  assign in_range = (end_addr <= (ADDR_W + 1)'(DEPTH));
  assign start_ok = (state == WL_IDLE) && start && in_range;
  // in_ready mirrors the LOAD state, so it doubles as the accept qualifier.
  assign accept   = in_valid && in_ready;

  transpose_addr_gen #(
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_ok),
    .advance (accept),
    .base    (base_q),
    .addr    (gen_addr),
    .last    (gen_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= WL_IDLE;
      base_q   <= '0;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      case (state)
        WL_IDLE: begin
          if (start) begin
            if (in_range) begin
              base_q   <= base_addr;
              state    <= WL_LOAD;
              in_ready <= 1'b1;
              busy     <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        WL_LOAD: begin
          if (accept) begin
            wr_en   <= 1'b1;
            wr_addr <= gen_addr;
            wr_data <= in_data;
            if (gen_last) begin
              state    <= WL_IDLE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        default: begin
          state    <= WL_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: stimulus queues expected writes, a
// negedge monitor checks every memory write against them.
module tb_weight_loader;
  import tpu_pkg::*;

  logic    clk = 1'b0;
  logic    reset;
  logic    start;
  waddr_t  base_addr;
  logic    in_valid;
  weight_t in_data;
  logic    in_ready;
  logic    wr_en;
  waddr_t  wr_addr;
  weight_t wr_data;
  logic    busy;
  logic    done;
  logic    err;

  typedef struct {
    logic [12:0] addr;
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   wr_cycles[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  weight_loader #(
    .N      (2),
    .DATA_W (16),
    .ADDR_W (13),
    .DEPTH  (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [12:0] b);
    start     = 1'b1;
    base_addr = b;
    tick();
    start     = 1'b0;
  endtask

  // Offers one beat and queues its hand-computed write; waits (bounded) for in_ready.
  task automatic send(input logic [15:0] d, input logic [12:0] exp_addr, input logic exp_last);
    int guard;
    exp_t e;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0 for data 0x%0h, expected 1", d);
    end else begin
      e.addr = exp_addr;
      e.data = d;
      e.last = exp_last;
      sb.push_back(e);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"},    wr_en,    0);
    chk({tag, "_wr_addr"},  wr_addr,  0);
    chk({tag, "_wr_data"},  wr_data,  0);
    chk({tag, "_done"},     done,     0);
    chk({tag, "_err"},      err,      0);
    chk({tag, "_busy"},     busy,     0);
    chk({tag, "_in_ready"}, in_ready, 0);
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (wr_en === 1'b1) begin
      wr_cycles.push_back(cyc);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", wr_addr, wr_data);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", wr_data, e.data);
        chk("wr_done", done, e.last);
        chk("wr_busy", busy, !e.last);
      end
    end else if (done !== 1'b0) begin
      chk("done_without_write", done, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    #1;
    chk_all_zero("reset");
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Basic transposed load
    n0 = wr_cycles.size();
    do_start(13'h0F);
    chk("basic_in_ready_up", in_ready, 1);
    chk("basic_busy_up", busy, 1);
    send(16'd3, 13'h0F, 1'b0);
    send(16'd4, 13'h11, 1'b0);
    send(16'd5, 13'h10, 1'b0);
    send(16'd6, 13'h12, 1'b1);
    tick();
    if (wr_cycles.size() >= n0 + 4)
      chk("basic_back_to_back", wr_cycles[n0+3] - wr_cycles[n0], 3);
    else
      chk("basic_write_count", wr_cycles.size() - n0, 4);
    chk("basic_busy_down", busy, 0);
    chk("basic_in_ready_down", in_ready, 0);

    // Stalled stream
    do_start(13'h0F);
    send(16'd3, 13'h0F, 1'b0);
    send(16'd4, 13'h11, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_busy", busy, 1);
      chk("stall_no_write", wr_en, 0);
    end
    send(16'd5, 13'h10, 1'b0);
    send(16'd6, 13'h12, 1'b1);
    tick();

    // Out-of-range base: err pulse, no writes, words in IDLE not consumed
    do_start(13'h1D);
    chk("oor_err", err, 1);
    chk("oor_in_ready", in_ready, 0);
    chk("oor_busy", busy, 0);
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    tick();
    chk("oor_err_one_cycle", err, 0);
    chk("oor_in_ready_hold", in_ready, 0);
    tick();
    in_valid = 1'b0;

    // Boundary base 28 + 4 = 32 accepted
    do_start(13'h1C);
    chk("bound_accept", busy, 1);
    chk("bound_no_err", err, 0);
    send(16'h0A, 13'h1C, 1'b0);
    send(16'h0B, 13'h1E, 1'b0);
    send(16'h0C, 13'h1D, 1'b0);
    send(16'h0D, 13'h1F, 1'b1);
    tick();

    // Start while busy is ignored; start on the done cycle is accepted
    do_start(13'h00);
    start     = 1'b1;
    base_addr = 13'h04;
    send(16'h21, 13'h00, 1'b0);
    start = 1'b0;
    send(16'h22, 13'h02, 1'b0);
    send(16'h23, 13'h01, 1'b0);
    send(16'h24, 13'h03, 1'b1);
    chk("busy_done_cycle", done, 1);
    do_start(13'h08);
    chk("restart_in_ready", in_ready, 1);
    chk("restart_busy", busy, 1);
    send(16'h31, 13'h08, 1'b0);
    send(16'h32, 13'h0A, 1'b0);
    send(16'h33, 13'h09, 1'b0);
    send(16'h34, 13'h0B, 1'b1);
    tick();

    // Reset mid-load: asynchronous clear, partial matrix abandoned
    do_start(13'h0F);
    send(16'h41, 13'h0F, 1'b0);
    send(16'h42, 13'h11, 1'b0);
    #5;
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    #10;
    reset = 1'b0;
    tick();
    chk("midreset_sb_empty", sb.size(), 0);
    chk("midreset_no_done", done, 0);
    do_start(13'h0F);
    send(16'd3, 13'h0F, 1'b0);
    send(16'd4, 13'h11, 1'b0);
    send(16'd5, 13'h10, 1'b0);
    send(16'd6, 13'h12, 1'b1);
    repeat (3) tick();
    chk("final_sb_drained", sb.size(), 0);
    chk("final_idle_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
